// File: rtl/time_display_driver_pkg.sv
// Shared definitions for the time display driver.
// Holds the controller state encoding, active-low 7-segment patterns
// ({g,f,e,d,c,b,a}), the digit indices that carry the colon, and the
// segment decode helper used by the scan output stage.
package time_display_driver_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_LOAD = 2'd2
  } ctrlStateT;

  // Two BCD digits per field
  localparam int BCD_W = 8;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Colon sits to the left of the seconds pair and the minutes pair
  localparam logic [2:0] COLON_IDX_LO = 3'd2;
  localparam logic [2:0] COLON_IDX_HI = 3'd4;
  localparam logic [2:0] DIGIT_LAST   = 3'd5;

  // Codes 10..15 cannot come out of the converter, but blank them anyway
  function automatic logic [6:0] segDecode(input logic [3:0] bcd);
    logic [6:0] seg;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/time_display_driver_bin2bcd_seq.sv
// Sequential shift-add-3 (double dabble) converter for one time field.
// A start pulse loads bin_i and performs the first shift on the same edge,
// so a WIDTH-bit field finishes after exactly WIDTH edges; done_o is high
// for the single cycle after the last shift, which lets converters be
// chained back to back with no idle cycle between fields.
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   start_i           begin converting bin_i (bin_i must be stable)
//   abort_i           drop any conversion and zero the result
//   bin_i             binary field value
//   done_o            result valid, one-cycle pulse
//   tens_o, ones_o    BCD result, held until the next start/abort
module bin2bcd_seq
  import time_display_driver_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [WIDTH-1:0] bin_i,
  output logic             done_o,
  output logic [3:0]       tens_o,
  output logic [3:0]       ones_o
);

  localparam int SW = WIDTH + BCD_W;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  logic [SW-1:0] shift_q, shift_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          active_q, active_d;
  logic [SW-1:0] stepIn, stepAdj, stepOut;

  // One dabble step: correct each BCD nibble that would overflow on the
  // doubling, then shift the whole register left by one.
  always_comb begin
    stepIn  = start_i ? {{BCD_W{1'b0}}, bin_i} : shift_q;
    stepAdj = stepIn;
    if (stepIn[SW-1 -: 4] >= 4'd5) stepAdj[SW-1 -: 4] = stepIn[SW-1 -: 4] + 4'd3;
    if (stepIn[SW-5 -: 4] >= 4'd5) stepAdj[SW-5 -: 4] = stepIn[SW-5 -: 4] + 4'd3;
    stepOut = {stepAdj[SW-2:0], 1'b0};

    shift_d  = shift_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    if (abort_i) begin
      shift_d  = '0;
      cnt_d    = '0;
      active_d = 1'b0;
    end else if (start_i) begin
      shift_d  = stepOut;
      cnt_d    = CW'(1);
      active_d = 1'b1;
    end else if (active_q && (cnt_q != LAST)) begin
      shift_d = stepOut;
      cnt_d   = cnt_q + 1'b1;
    end else if (active_q) begin
      active_d = 1'b0;
    end
  end

  // Conversion state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_q  <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

  assign done_o = active_q && (cnt_q == LAST);
  assign tens_o = shift_q[SW-1 -: 4];
  assign ones_o = shift_q[SW-5 -: 4];

endmodule

// File: rtl/time_display_driver.sv
// Six-digit multiplexed 7-segment driver for an hh:mm:ss clock.
// An update request latches i_time, converts hour, minute and second to
// BCD one after another and then loads all six digits in a single cycle.
// A free-running scan walks the digit enables; the decimal point of digits
// 2 and 4 forms the colon. Optional blinking while paused is enabled by
// defining DISPLAY_BLINK_EN.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   i_time         packed {hour,min,sec} binary time
//   i_update       request capture/conversion (ignored while o_busy)
//   i_clear        synchronous clear of digits, aborts conversion
//   i_pausing      blanks the display on alternate blink phases (blink build)
//   o_busy         conversion/load in progress
//   o_an           active-low digit enables, bit0 = sec ones
//   o_seg          active-low segments {g,f,e,d,c,b,a}
//   o_dp           active-low decimal point (colon)
module time_display_driver
  import time_display_driver_pkg::*;
#(
  parameter int SEC_BIT  = 6,
  parameter int MIN_BIT  = 6,
  parameter int HOUR_BIT = 6,
  parameter int SCAN_TH  = 100000,
  parameter int BLINK_TH = 25000000
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [HOUR_BIT+MIN_BIT+SEC_BIT-1:0] i_time,
  input  logic                            i_update,
  input  logic                            i_clear,
  input  logic                            i_pausing,
  output logic                            o_busy,
  output logic [5:0]                      o_an,
  output logic [6:0]                      o_seg,
  output logic                            o_dp
);

  localparam int TW     = HOUR_BIT + MIN_BIT + SEC_BIT;
  localparam int SCAN_W = (SCAN_TH > 1) ? $clog2(SCAN_TH) : 1;

  ctrlStateT         state_q, state_d;
  logic [TW-1:0]     timeLatch_q, timeLatch_d;
  logic              hourStart_q, hourStart_d;
  logic [5:0][3:0]   digits_q, digits_d;

  logic              minStart, secStart, secDone;
  logic [3:0]        hourTens, hourOnes, minTens, minOnes, secTens, secOnes;

  logic [SCAN_W-1:0] scanCnt_q, scanCnt_d;
  logic [2:0]        digitIdx_q, digitIdx_d;
  logic              scanEn_q, scanEn_d;
  logic              scanTerm;
  logic              blank;

  // Fields are converted in hour, minute, second order; each converter's
  // done pulse starts the next so the shifts run back to back.
  bin2bcd_seq #(.WIDTH(HOUR_BIT)) hourConv (
    .clk(clk), .reset_n(reset_n), .start_i(hourStart_q), .abort_i(i_clear),
    .bin_i(timeLatch_q[TW-1 -: HOUR_BIT]), .done_o(minStart),
    .tens_o(hourTens), .ones_o(hourOnes)
  );

  bin2bcd_seq #(.WIDTH(MIN_BIT)) minConv (
    .clk(clk), .reset_n(reset_n), .start_i(minStart), .abort_i(i_clear),
    .bin_i(timeLatch_q[SEC_BIT +: MIN_BIT]), .done_o(secStart),
    .tens_o(minTens), .ones_o(minOnes)
  );

  bin2bcd_seq #(.WIDTH(SEC_BIT)) secConv (
    .clk(clk), .reset_n(reset_n), .start_i(secStart), .abort_i(i_clear),
    .bin_i(timeLatch_q[SEC_BIT-1:0]), .done_o(secDone),
    .tens_o(secTens), .ones_o(secOnes)
  );

  // Controller next state. The hour converter is kicked one cycle after
  // acceptance, from the latched copy, so the converters never see i_time
  // change under them. Clear overrides everything, including an update.
  always_comb begin
    state_d     = state_q;
    timeLatch_d = timeLatch_q;
    hourStart_d = 1'b0;
    digits_d    = digits_q;
    if (i_clear) begin
      state_d  = S_IDLE;
      digits_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_update) begin
            state_d     = S_CONV;
            timeLatch_d = i_time;
            hourStart_d = 1'b1;
          end
        end
        S_CONV: begin
          if (secDone) state_d = S_LOAD;
        end
        S_LOAD: begin
          digits_d = {hourTens, hourOnes, minTens, minOnes, secTens, secOnes};
          state_d  = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Controller registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      timeLatch_q <= '0;
      hourStart_q <= 1'b0;
      digits_q    <= '0;
    end else begin
      state_q     <= state_d;
      timeLatch_q <= timeLatch_d;
      hourStart_q <= hourStart_d;
      digits_q    <= digits_d;
    end
  end

  assign o_busy = (state_q != S_IDLE);

  // Scan timing. The display stays dark until the first terminal count;
  // that terminal only enables the outputs so the walk starts on digit 0,
  // later terminals advance the index.
  assign scanTerm = (scanCnt_q == SCAN_W'(SCAN_TH - 1));

  always_comb begin
    scanCnt_d  = scanCnt_q + 1'b1;
    digitIdx_d = digitIdx_q;
    scanEn_d   = scanEn_q;
    if (scanTerm) begin
      scanCnt_d = '0;
      scanEn_d  = 1'b1;
      if (scanEn_q) digitIdx_d = (digitIdx_q == DIGIT_LAST) ? 3'd0 : digitIdx_q + 3'd1;
    end
  end

  // Scan registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scanCnt_q  <= '0;
      digitIdx_q <= '0;
      scanEn_q   <= 1'b0;
    end else begin
      scanCnt_q  <= scanCnt_d;
      digitIdx_q <= digitIdx_d;
      scanEn_q   <= scanEn_d;
    end
  end

`ifdef DISPLAY_BLINK_EN
  localparam int BLINK_W = (BLINK_TH > 1) ? $clog2(BLINK_TH) : 1;

  logic [BLINK_W-1:0] blinkCnt_q, blinkCnt_d;
  logic               blinkPhase_q, blinkPhase_d;

  // Blink phase flips every BLINK_TH cycles regardless of i_pausing
  always_comb begin
    blinkCnt_d   = blinkCnt_q + 1'b1;
    blinkPhase_d = blinkPhase_q;
    if (blinkCnt_q == BLINK_W'(BLINK_TH - 1)) begin
      blinkCnt_d   = '0;
      blinkPhase_d = ~blinkPhase_q;
    end
  end

  // Blink registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blinkCnt_q   <= '0;
      blinkPhase_q <= 1'b0;
    end else begin
      blinkCnt_q   <= blinkCnt_d;
      blinkPhase_q <= blinkPhase_d;
    end
  end

  assign blank = i_pausing && blinkPhase_q;
`else
  logic unusedBlink;
  assign unusedBlink = i_pausing ^ (BLINK_TH > 0);
  assign blank       = 1'b0;
`endif

  // Output stage: one active-low enable for the current digit, its decoded
  // segments, and the colon dot on digits 2 and 4.
  always_comb begin
    o_an  = 6'b111111;
    o_seg = SEG_BLANK;
    o_dp  = 1'b1;
    if (scanEn_q) begin
      o_an  = ~(6'b000001 << digitIdx_q);
      o_seg = segDecode(digits_q[digitIdx_q]);
      o_dp  = !((digitIdx_q == COLON_IDX_LO) || (digitIdx_q == COLON_IDX_HI));
    end
    if (blank) o_an = 6'b111111;
  end

endmodule

// File: tb/tb_time_display_driver.sv
// Self-checking bench for time_display_driver with a fast scan (4 cycles
// per digit) and blink period (8 cycles). A behavioural model tracks the
// displayed time as integers and derives scan position and blink phase
// from the number of clock edges since reset release.
module tb_time_display_driver;

  localparam int SCAN  = 4;
  localparam int BLINK = 8;

  localparam logic [6:0] SEGTAB [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [17:0] i_time = '0;
  logic        i_update = 1'b0;
  logic        i_clear = 1'b0;
  logic        i_pausing = 1'b0;
  logic        o_busy;
  logic [5:0]  o_an;
  logic [6:0]  o_seg;
  logic        o_dp;

  int checks = 0;
  int passes = 0;
  bit checkEn = 1'b0;

  // Model state
  int edges = 0;
  bit mBusy = 1'b0;
  int acceptEdge = 0;
  int mH = 0, mM = 0, mS = 0;
  int pH = 0, pM = 0, pS = 0;

  time_display_driver #(
    .SEC_BIT(6), .MIN_BIT(6), .HOUR_BIT(6), .SCAN_TH(SCAN), .BLINK_TH(BLINK)
  ) dut (
    .clk(clk), .reset_n(reset_n), .i_time(i_time), .i_update(i_update),
    .i_clear(i_clear), .i_pausing(i_pausing), .o_busy(o_busy), .o_an(o_an),
    .o_seg(o_seg), .o_dp(o_dp)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic upd, input logic clr, input logic [17:0] t);
    i_update = upd;
    i_clear  = clr;
    i_time   = t;
    @(posedge clk); #1;
    i_update = 1'b0;
    i_clear  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic waitAn(input logic [5:0] an, input string name);
    bit found = 1'b0;
    for (int i = 0; i < 150 && !found; i++) begin
      @(negedge clk);
      if (o_an === an) found = 1'b1;
    end
    checkOutput({name, "_reached"}, {31'd0, found}, 32'd1);
  endtask

  // Model: edge count since reset, 20-cycle busy window, atomic digit load
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edges = 0; mBusy = 1'b0; mH = 0; mM = 0; mS = 0;
    end else begin
      edges++;
      if (i_clear) begin
        mBusy = 1'b0; mH = 0; mM = 0; mS = 0;
      end else if (mBusy) begin
        if (edges == acceptEdge + 20) begin
          mBusy = 1'b0; mH = pH; mM = pM; mS = pS;
        end
      end else if (i_update) begin
        mBusy = 1'b1; acceptEdge = edges;
        pH = int'(i_time[17:12]); pM = int'(i_time[11:6]); pS = int'(i_time[5:0]);
      end
    end
  end

  // Compare DUT outputs against the model every cycle
  always @(negedge clk) begin
    if (checkEn && reset_n) begin
      logic [5:0] expAn;
      logic [6:0] expSeg;
      logic       expDp;
      int idx, val;
      expAn = 6'h3F; expSeg = 7'h7F; expDp = 1'b1;
      if (edges >= SCAN) begin
        idx = ((edges - SCAN) / SCAN) % 6;
        case (idx)
          0: val = mS % 10;
          1: val = mS / 10;
          2: val = mM % 10;
          3: val = mM / 10;
          4: val = mH % 10;
          default: val = mH / 10;
        endcase
        expAn  = 6'h3F ^ (6'd1 << idx);
        expSeg = SEGTAB[val];
        expDp  = !(idx == 2 || idx == 4);
      end
`ifdef DISPLAY_BLINK_EN
      if (i_pausing && ((edges / BLINK) % 2 == 1)) expAn = 6'h3F;
`endif
      checkOutput("model_an", {26'd0, o_an}, {26'd0, expAn});
      checkOutput("model_seg", {25'd0, o_seg}, {25'd0, expSeg});
      checkOutput("model_dp", {31'd0, o_dp}, {31'd0, expDp});
      checkOutput("model_busy", {31'd0, o_busy}, {31'd0, mBusy});
    end
  end

  initial begin
    logic [5:0] walkAn [7];
    logic       walkDp [7];
    logic [5:0] expWalk [7];
    logic       expWalkDp [7];
    int busyCycles, guard, n, blanks, r;
    logic [5:0] prev;

    expWalk   = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F, 6'h3E};
    expWalkDp = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_an", {26'd0, o_an}, 32'h3F);
    checkOutput("reset_seg", {25'd0, o_seg}, 32'h7F);
    checkOutput("reset_dp", {31'd0, o_dp}, 32'd1);
    checkOutput("reset_busy", {31'd0, o_busy}, 32'd0);
    reset_n = 1'b1;
    checkEn = 1'b1;
    idle(3);

    // Update 05:34:12, a second update mid-conversion must be dropped
    applyStimulus(1'b1, 1'b0, {6'd5, 6'd34, 6'd12});
    busyCycles = 0;
    guard = 0;
    while (o_busy && guard < 60) begin
      busyCycles++;
      guard++;
      i_update = (busyCycles == 5);
      i_time   = {6'd23, 6'd59, 6'd59};
      @(posedge clk); #1;
    end
    i_update = 1'b0;
    checkOutput("busy_len", busyCycles, 32'd20);
    idle(3);
    checkOutput("busy_not_requeued", {31'd0, o_busy}, 32'd0);

    waitAn(6'b111110, "idx0");
    checkOutput("idx0_seg_2", {25'd0, o_seg}, {25'd0, 7'b0100100});
    waitAn(6'b110111, "idx3");
    checkOutput("idx3_seg_3", {25'd0, o_seg}, {25'd0, 7'b0110000});
    waitAn(6'b101111, "idx4");
    checkOutput("idx4_seg_5", {25'd0, o_seg}, {25'd0, 7'b0010010});
    checkOutput("idx4_dp", {31'd0, o_dp}, 32'd0);
    waitAn(6'b011111, "idx5");
    checkOutput("idx5_seg_0", {25'd0, o_seg}, {25'd0, 7'b1000000});

    // Digit walk and colon positions
    waitAn(6'b111110, "walk_start");
    walkAn[0] = o_an;
    walkDp[0] = o_dp;
    n = 1;
    prev = o_an;
    for (int i = 0; i < 60 && n < 7; i++) begin
      @(negedge clk);
      if (o_an !== prev && o_an !== 6'h3F) begin
        walkAn[n] = o_an;
        walkDp[n] = o_dp;
        n++;
      end
      prev = o_an;
    end
    for (int i = 0; i < 7; i++) begin
      checkOutput($sformatf("walk_an%0d", i), {26'd0, walkAn[i]}, {26'd0, expWalk[i]});
      checkOutput($sformatf("walk_dp%0d", i), {31'd0, walkDp[i]}, {31'd0, expWalkDp[i]});
    end
    idle(1);

    // Clear and update together mid-conversion: clear wins
    applyStimulus(1'b1, 1'b0, {6'd1, 6'd2, 6'd3});
    idle(6);
    applyStimulus(1'b1, 1'b1, {6'd9, 6'd9, 6'd9});
    checkOutput("clear_busy", {31'd0, o_busy}, 32'd0);
    idle(25);
    waitAn(6'b111110, "clear_idx0");
    checkOutput("clear_seg_0", {25'd0, o_seg}, {25'd0, 7'b1000000});
    idle(1);

    // Blinking while paused: 32 blank cycles in any 64-cycle window
    i_pausing = 1'b1;
    blanks = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (o_an === 6'h3F) blanks++;
    end
`ifdef DISPLAY_BLINK_EN
    checkOutput("blink_paused", blanks, 32'd32);
`else
    checkOutput("blink_paused", blanks, 32'd0);
`endif
    i_pausing = 1'b0;
    blanks = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (o_an === 6'h3F) blanks++;
    end
    checkOutput("blink_running", blanks, 32'd0);
    idle(1);

    // Random traffic against the model
    for (int c = 0; c < 500; c++) begin
      r = int'($urandom_range(0, 99));
      i_time = {6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63))};
      i_update = (r < 15);
      i_clear = (r >= 97);
      if (c % 50 == 0) i_pausing = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    i_update = 1'b0;
    i_clear = 1'b0;
    i_pausing = 1'b0;

    // Reset mid-conversion discards the partial result
    applyStimulus(1'b1, 1'b0, {6'd47, 6'd38, 6'd29});
    idle(8);
    reset_n = 1'b0;
    #1;
    checkOutput("midreset_busy", {31'd0, o_busy}, 32'd0);
    checkOutput("midreset_an", {26'd0, o_an}, 32'h3F);
    checkOutput("midreset_seg", {25'd0, o_seg}, 32'h7F);
    @(posedge clk); #1;
    reset_n = 1'b1;
    idle(30);
    waitAn(6'b101111, "midreset_idx4");
    checkOutput("midreset_seg_0", {25'd0, o_seg}, {25'd0, 7'b1000000});
    idle(10);

    checkEn = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/time_display_driver.md
TIME_DISPLAY_DRIVER -- requirements
Module: time_display_driver

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
  SEC_BIT, 6, seconds field width.
  MIN_BIT, 6, minutes field width.
  HOUR_BIT, 6, hours field width.
  SCAN_TH, 100000, clk cycles per digit scan slot.
  BLINK_TH, 25000000, clk cycles per blink half-period.
REQ-002 SHALL have ports, one per line: name, direction, width, meaning.
  clk, in, 1, clock.
  reset_n, in, 1, asynchronous active-low reset.
  i_time, in, HOUR_BIT+MIN_BIT+SEC_BIT, packed {hour,min,sec} binary time.
  i_update, in, 1, request capture and conversion of i_time.
  i_clear, in, 1, synchronous clear of displayed digits.
  i_pausing, in, 1, watch paused; drives blink when enabled.
  o_busy, out, 1, conversion in progress; i_update ignored while high.
  o_an, out, 6, active-low digit enables; bit0 = sec ones, bit5 = hour tens.
  o_seg, out, 7, active-low segments {g,f,e,d,c,b,a}.
  o_dp, out, 1, active-low decimal point used as colon.
REQ-003 Reset: reset_n, asynchronous, active-low; clock: clk.

Function
REQ-010 Controller FSM states SHALL be S_IDLE, S_CONV, S_LOAD.
REQ-011 S_IDLE -> S_CONV when i_update=1 and i_clear=0; i_time latched that edge.
REQ-012 S_CONV SHALL convert hour, min, sec fields in that order by shift-add-3, HOUR_BIT/MIN_BIT/SEC_BIT shift cycles each (18 total at defaults), then -> S_LOAD.
REQ-013 S_LOAD SHALL write all six digit registers in one cycle (atomic update), then -> S_IDLE.
REQ-014 o_busy SHALL be 1 in S_CONV and S_LOAD, 0 in S_IDLE; new digits visible at 20 cycles after i_update acceptance at defaults.
REQ-015 i_update while o_busy=1 SHALL be ignored, not queued.
REQ-016 i_clear=1 SHALL zero all digit registers next edge and force S_IDLE, aborting any conversion; i_clear wins over simultaneous i_update.
REQ-017 Field values 0..63 SHALL yield two BCD digits each; tens digit 0 displayed as '0' (no blanking).
REQ-018 Scan counter SHALL count 0..SCAN_TH-1; at terminal count digit index advances 0..5 and wraps to 0.
REQ-019 Exactly one o_an bit SHALL be low, matching digit index; o_seg SHALL show that digit's decoded pattern; non-BCD codes show all segments off.
REQ-020 o_dp SHALL be 0 on digit indices 2 and 4 (colon positions), 1 otherwise.
REQ-021 Scan SHALL run continuously, independent of FSM state.

Reset
REQ-030 On reset: o_an=6'b111111, o_seg=7'b1111111, o_dp=1, o_busy=0, FSM S_IDLE, digit registers, scan/blink counters and digit index 0.
REQ-031 First enabled digit SHALL appear after first scan terminal count following reset release.
REQ-032 Reset mid-conversion SHALL discard partial results.

Configuration
REQ-040 Macro DISPLAY_BLINK_EN defined: blink counter toggles phase every BLINK_TH cycles; when i_pausing=1 and phase=1, o_an SHALL be 6'b111111; when i_pausing=0 display is steady.
REQ-041 Macro undefined: no blink logic; i_pausing SHALL be ignored.

Structure
REQ-050 Shared package SHALL hold FSM state encodings, 7-segment pattern constants for 0..9 and blank, and colon digit indices.
REQ-051 Sub-module bin2bcd_seq SHALL implement per-field sequential shift-add-3 conversion with start/done handshake.

Verification
REQ-060 Reset asserted -> o_an=6'b111111, o_seg=7'b1111111, o_busy=0.
REQ-061 SCAN_TH=4, i_time={5,34,12}, pulse i_update -> o_busy high 20 cycles; then index 0 o_seg=7'b0100100 ('2'), index 5 o_seg=7'b1000000 ('0').
REQ-062 Second i_update with {23,59,59} while o_busy=1 -> ignored; digits remain 05 34 12.
REQ-063 i_clear and i_update same cycle mid-conversion -> o_busy=0 next cycle, all digits '0'.
REQ-064 Scan over 6 slots -> o_an walks 111110..011111, wraps; o_dp=0 only on indices 2, 4.
REQ-065 DISPLAY_BLINK_EN, BLINK_TH=8, i_pausing=1 -> o_an all high every alternate 8-cycle window; i_pausing=0 -> never blanked.
